// File: rtl/alu_pkg.sv
// Shared constants, FSM encoding and helpers for the ALU initiator.
package alu_pkg;

    localparam int unsigned TAG_W   = 3;
    localparam int unsigned NUM_OPS = 8;

    localparam logic [TAG_W-1:0] OP_ADD = 3'd0;
    localparam logic [TAG_W-1:0] OP_SUB = 3'd1;
    localparam logic [TAG_W-1:0] OP_AND = 3'd2;
    localparam logic [TAG_W-1:0] OP_OR  = 3'd3;
    localparam logic [TAG_W-1:0] OP_XOR = 3'd4;
    localparam logic [TAG_W-1:0] OP_NOT = 3'd5;
    localparam logic [TAG_W-1:0] OP_MUL = 3'd6;
    localparam logic [TAG_W-1:0] OP_DIV = 3'd7;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [TAG_W-1:0] lowest_op(input logic [NUM_OPS-1:0] mask);
        logic [TAG_W-1:0] idx;
        idx = '0;
        for (int i = int'(NUM_OPS) - 1; i >= 0; i--) begin
            if (mask[i]) idx = TAG_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

endpackage

// File: rtl/alu_tag_pipe.sv
// LATENCY-deep {valid, opcode} shift register tracking results in flight.
module alu_tag_pipe
    import alu_pkg::*;
#(
    parameter int unsigned LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid,
    input  logic [TAG_W-1:0] push_tag,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic             inner_valid
);

    logic [LATENCY-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < int'(LATENCY); i++) tag_q[i] <= '0;
        end else begin
            valid_q[0] <= push_valid;
            tag_q[0]   <= push_tag;
            for (int i = 1; i < int'(LATENCY); i++) begin
                valid_q[i] <= valid_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_tag   = tag_q[LATENCY-1];

    // Entries that will still be in flight after the current output is consumed.
    always_comb begin
        inner_valid = 1'b0;
        for (int i = 0; i < int'(LATENCY) - 1; i++) inner_valid = inner_valid | valid_q[i];
    end

endmodule

// File: rtl/alu_initiator.sv
// Issues enabled opcodes to a pipelined ALU responder and collects the results.
module alu_initiator
    import alu_pkg::*;
#(
    parameter int unsigned LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       a_in,
    input  logic [3:0]       b_in,
    input  logic [7:0]       op_mask,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [TAG_W-1:0] alu_sel,
    input  logic [7:0]       alu_result,
    output logic             busy,
    output logic             done,
    output logic [7:0]       sig_out,
    output logic [3:0]       res_count,
    input  logic [2:0]       rd_addr,
    output logic [7:0]       rd_data
);

    state_e             state_q, state_d;
    logic [3:0]         a_q, a_d, b_q, b_d;
    logic [TAG_W-1:0]   sel_q, sel_d;
    logic [NUM_OPS-1:0] pending_q, pending_d;
    logic [7:0]         sig_q;
    logic [3:0]         cnt_q;
    logic [7:0]         mem_q [NUM_OPS];
    logic               launch;
    logic               cap_valid, inner_valid;
    logic [TAG_W-1:0]   cap_tag;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sel_d     = sel_q;
        pending_d = pending_q;
        launch    = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    launch = 1'b1;
                    a_d    = a_in;
                    b_d    = b_in;
                    if (op_mask != '0) begin
                        state_d   = StIssue;
                        sel_d     = lowest_op(op_mask);
                        pending_d = op_mask & (op_mask - 8'd1);
                    end else begin
                        state_d   = StDone;
                        pending_d = '0;
                    end
                end
            end
            StIssue: begin
                // alu_sel already holds the opcode issued this cycle; pick the next one.
                if (pending_q == '0) begin
                    state_d = StDrain;
                end else begin
                    sel_d     = lowest_op(pending_q);
                    pending_d = pending_q & (pending_q - 8'd1);
                end
            end
            StDrain: begin
                if (!inner_valid) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            sel_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sel_q     <= sel_d;
            pending_q <= pending_d;
        end
    end

    // Tag is pushed on the edge where the responder samples alu_sel.
    alu_tag_pipe #(
        .LATENCY (LATENCY)
    ) u_tag_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_valid  (state_q == StIssue),
        .push_tag    (sel_q),
        .out_valid   (cap_valid),
        .out_tag     (cap_tag),
        .inner_valid (inner_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(NUM_OPS); i++) mem_q[i] <= '0;
        end else if (launch) begin
            sig_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(NUM_OPS); i++) mem_q[i] <= '0;
        end else if (cap_valid) begin
            mem_q[cap_tag] <= alu_result;
            sig_q          <= rotl1(sig_q) ^ alu_result;
            if (cnt_q != 4'd8) cnt_q <= cnt_q + 4'd1;
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_sel   = sel_q;
    assign busy      = (state_q == StIssue) || (state_q == StDrain);
    assign done      = (state_q == StDone);
    assign sig_out   = sig_q;
    assign res_count = cnt_q;
    assign rd_data   = mem_q[rd_addr];

endmodule

// File: tb/tb_alu_initiator.sv
// Directed-vector bench: four initiators (LATENCY 1..4) driven in lockstep, each with its own responder.
module tb_alu_initiator;
    import alu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a_in, b_in;
    logic [7:0] op_mask;
    logic [2:0] rd_addr;

    logic [3:0] alu_a_w      [4];
    logic [3:0] alu_b_w      [4];
    logic [2:0] alu_sel_w    [4];
    logic [7:0] alu_result_w [4];
    logic [7:0] sig_w        [4];
    logic [3:0] cnt_w        [4];
    logic [7:0] rd_data_w    [4];
    logic [3:0] busy_w, done_w;

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] sel);
        logic [7:0] ea, eb;
        ea = {4'h0, a};
        eb = {4'h0, b};
        case (sel)
            OP_ADD:  return ea + eb;
            OP_SUB:  return ea - eb;
            OP_AND:  return ea & eb;
            OP_OR:   return ea | eb;
            OP_XOR:  return ea ^ eb;
            OP_NOT:  return ~{b, a};
            OP_MUL:  return ea * eb;
            default: return (b == 4'h0) ? 8'h00 : ea / eb;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_inst
        localparam int unsigned LAT = g + 1;
        logic [7:0] rsp_q [LAT];

        alu_initiator #(
            .LATENCY (LAT)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start),
            .a_in       (a_in),
            .b_in       (b_in),
            .op_mask    (op_mask),
            .alu_a      (alu_a_w[g]),
            .alu_b      (alu_b_w[g]),
            .alu_sel    (alu_sel_w[g]),
            .alu_result (alu_result_w[g]),
            .busy       (busy_w[g]),
            .done       (done_w[g]),
            .sig_out    (sig_w[g]),
            .res_count  (cnt_w[g]),
            .rd_addr    (rd_addr),
            .rd_data    (rd_data_w[g])
        );

        always @(posedge clk) begin
            rsp_q[0] <= alu_ref(alu_a_w[g], alu_b_w[g], alu_sel_w[g]);
            for (int i = 1; i < int'(LAT); i++) rsp_q[i] <= rsp_q[i-1];
        end
        assign alu_result_w[g] = rsp_q[LAT-1];
    end

    typedef struct {
        logic [3:0]      a;
        logic [3:0]      b;
        logic [7:0]      mask;
        logic [7:0][7:0] mem;
        logic [7:0]      sig;
        logic [3:0]      cnt;
        int              busy_cyc;
        int              done_at;
        logic [2:0]      sel1;
        logic [2:0]      sel2;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(input logic [3:0] a, input logic [3:0] b, input logic [7:0] mask,
                                input logic [63:0] mem, input logic [7:0] sig,
                                input logic [3:0] cnt, input int busy_cyc, input int done_at,
                                input logic [2:0] sel1, input logic [2:0] sel2);
        vec_t v;
        v.a = a; v.b = b; v.mask = mask; v.mem = mem; v.sig = sig; v.cnt = cnt;
        v.busy_cyc = busy_cyc; v.done_at = done_at; v.sel1 = sel1; v.sel2 = sel2;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_mem(input string tag, input int g, input logic [63:0] exp);
        logic [7:0] e;
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            e = exp[8*i +: 8];
            check($sformatf("%s L%0d mem[%0d]", tag, g + 1, i), rd_data_w[g], e);
        end
    endtask

    task automatic wait_all_done(input string tag);
        int c;
        c = 0;
        while (done_w != 4'hF && c < 80) begin
            @(negedge clk);
            c++;
        end
        check({tag, " all done before timeout"}, done_w, 4'hF);
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        int         busy_n;
        int         done_at;
        logic [2:0] s1, s2;
        string      tag;
        busy_n  = 0;
        done_at = 0;
        s1      = '0;
        s2      = '0;
        tag     = $sformatf("v%0d", vi);
        @(negedge clk);
        a_in    = v.a;
        b_in    = v.b;
        op_mask = v.mask;
        start   = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 1) s1 = alu_sel_w[1];
            if (c == 2) s2 = alu_sel_w[1];
            if (busy_w[1]) busy_n++;
            if (done_w[1] && done_at == 0) done_at = c;
            if (done_w == 4'hF && c >= 2) break;
        end
        check({tag, " all done before timeout"}, done_w, 4'hF);
        check({tag, " busy cycles"}, busy_n, v.busy_cyc);
        check({tag, " done cycle"}, done_at, v.done_at);
        check({tag, " alu_sel cycle1"}, s1, v.sel1);
        check({tag, " alu_sel cycle2"}, s2, v.sel2);
        check({tag, " alu_a"}, alu_a_w[1], v.a);
        check({tag, " alu_b"}, alu_b_w[1], v.b);
        for (int g = 0; g < 4; g++) begin
            check($sformatf("%s L%0d sig_out", tag, g + 1), sig_w[g], v.sig);
            check($sformatf("%s L%0d res_count", tag, g + 1), cnt_w[g], v.cnt);
            check_mem(tag, g, v.mem);
        end
    endtask

    initial begin
        vecs[0] = mk(4'd6, 4'd3, 8'hFF, 64'h02_12_C9_05_07_02_03_09, 8'h5D, 4'd8, 10, 11, 3'd0, 3'd1);
        vecs[1] = mk(4'd15, 4'd15, 8'h41, 64'h00_E1_00_00_00_00_00_1E, 8'hDD, 4'd2, 4, 5, 3'd0, 3'd6);
        vecs[2] = mk(4'd9, 4'd0, 8'h80, 64'h0, 8'h00, 4'd1, 3, 4, 3'd7, 3'd7);
        vecs[3] = mk(4'd7, 4'd1, 8'h00, 64'h0, 8'h00, 4'd0, 0, 1, 3'd7, 3'd7);
        vecs[4] = mk(4'd5, 4'd2, 8'h24, 64'h00_00_DA_00_00_00_00_00, 8'hDA, 4'd2, 4, 5, 3'd2, 3'd5);
        vecs[5] = mk(4'd3, 4'd9, 8'h02, 64'h00_00_00_00_00_00_FA_00, 8'hFA, 4'd1, 3, 4, 3'd1, 3'd1);
        vecs[6] = mk(4'd12, 4'd5, 8'h82, 64'h02_00_00_00_00_00_07_00, 8'h0C, 4'd2, 4, 5, 3'd1, 3'd7);

        rst_n   = 1'b0;
        start   = 1'b0;
        a_in    = '0;
        b_in    = '0;
        op_mask = '0;
        rd_addr = '0;

        // Reset values, before any clock edge.
        #3;
        check("reset busy", busy_w, 4'h0);
        check("reset done", done_w, 4'h0);
        check("reset sig_out", sig_w[1], 8'h00);
        check("reset res_count", cnt_w[1], 4'd0);
        check("reset alu_a", alu_a_w[1], 4'd0);
        check("reset alu_b", alu_b_w[1], 4'd0);
        check("reset alu_sel", alu_sel_w[1], 3'd0);
        check_mem("reset", 1, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int vi = 0; vi < 7; vi++) run_vec(vecs[vi], vi);

        // start pulsed mid-ISSUE must be ignored.
        @(negedge clk);
        a_in = 4'd6; b_in = 4'd3; op_mask = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("midissue busy before pulse", busy_w, 4'hF);
        a_in = 4'd1; b_in = 4'd1; op_mask = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_all_done("midissue");
        check("midissue alu_a", alu_a_w[1], 4'd6);
        for (int g = 0; g < 4; g++) begin
            check($sformatf("midissue L%0d sig_out", g + 1), sig_w[g], 8'h5D);
            check($sformatf("midissue L%0d res_count", g + 1), cnt_w[g], 4'd8);
        end
        check_mem("midissue", 1, 64'h02_12_C9_05_07_02_03_09);

        // Reset asserted mid-DRAIN: everything clears at once and nothing is captured later.
        @(negedge clk);
        a_in = 4'd6; b_in = 4'd3; op_mask = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("middrain busy", busy_w[1], 1'b1);
        check("middrain count before reset", cnt_w[1], 4'd6);
        rst_n = 1'b0;
        #1;
        check("middrain reset busy", busy_w, 4'h0);
        check("middrain reset done", done_w, 4'h0);
        check("middrain reset sig_out", sig_w[1], 8'h00);
        check("middrain reset res_count", cnt_w[1], 4'd0);
        check("middrain reset alu_a", alu_a_w[1], 4'd0);
        check("middrain reset alu_sel", alu_sel_w[1], 3'd0);
        check_mem("middrain reset", 1, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            check($sformatf("postreset L%0d res_count", g + 1), cnt_w[g], 4'd0);
            check($sformatf("postreset L%0d sig_out", g + 1), sig_w[g], 8'h00);
        end
        check("postreset done", done_w, 4'h0);
        check("postreset busy", busy_w, 4'h0);
        check_mem("postreset", 3, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
